clksel_ctrl: RTL and testbench
==============================

Name: clksel_ctrl

Overview:
- Requester side of the CPU clock-switch handshake. Decides when the CPU runs on the fast clock and drives `hsclk_sel` to the clock switch.
- Waits for the switch's `hsclk_selected`/`lsclk_selected` acknowledges before it treats a transition as complete.
- Sits between the address decode (which flags slow-bus accesses) and the clock switch. Runs entirely on the fast clock.

Parameters:
- SYNC_STAGES, 2, flop depth of each acknowledge synchroniser (>=2).
- LS_HOLD, 8, minimum hsclk_in cycles spent settled in LS (and after `slow_req` falls) before a fast switch is requested.
- TIMEOUT, 255, max hsclk_in cycles waiting for an acknowledge before the timeout action.
- CNT_W, 8, width of the holdoff and timeout counters (must hold max(LS_HOLD, TIMEOUT)).

Ports:
- hsclk_in  input  1  fast clock; the only clock.
- rst_b  input  1  asynchronous active-low reset.
- turbo_en  input  1  level; fast mode permitted.
- slow_req  input  1  level from address decode; the current/next CPU access needs the slow clock.
- hsclk_selected  input  1  acknowledge from the clock switch, other domain; synchronised internally.
- lsclk_selected  input  1  acknowledge from the clock switch, lsclk domain; synchronised internally.
- err_clr  input  1  single-cycle pulse; clears `timeout_err`.
- hsclk_sel  output  1  registered request to the clock switch (1 = fast).
- hs_active  output  1  registered; 1 only when settled in fast mode.
- busy  output  1  registered; 1 while a switch is in flight.
- timeout_err  output  1  sticky; an acknowledge wait timed out.

Behaviour:
- Reset (rst_b low, asynchronous):
  - state=LS, hsclk_sel=0, hs_active=0, busy=0, timeout_err=0.
  - Holdoff counter=LS_HOLD, timeout counter=0.
  - hs_ack synchroniser flops reset to 0; ls_ack synchroniser flops reset to 1.
- Synchronisers: hs_ack_s and ls_ack_s are the last flop of a SYNC_STAGES chain. Only hs_ack_s and ls_ack_s are used in decisions.
- State LS (hsclk_sel=0):
  - If slow_req=1 or turbo_en=0, reload holdoff to LS_HOLD; otherwise decrement holdoff, saturating at 0.
  - Go to GO_HS when turbo_en=1, slow_req=0 and holdoff==0.
- State GO_HS (hsclk_sel=1, busy=1):
  - Timeout counter increments each cycle.
  - Go to HS when hs_ack_s=1 and ls_ack_s=0.
  - If the counter reaches TIMEOUT first: set timeout_err and go to GO_LS.
  - slow_req or turbo_en changes do NOT abort; the handshake always completes or times out.
- State HS (hsclk_sel=1, hs_active=1):
  - Go to GO_LS on slow_req=1 or turbo_en=0. The exit is decided in the same cycle; hsclk_sel falls on the next edge.
- State GO_LS (hsclk_sel=0, busy=1):
  - Go to LS when ls_ack_s=1 and hs_ack_s=0; holdoff loads LS_HOLD on entry to LS.
  - On reaching TIMEOUT: set timeout_err and keep waiting. LS is the only safe fallback, so there is no further transition.
- Timeout counter clears on every state change and saturates at TIMEOUT.
- All outputs are registered from the next-state decode, so they change exactly on the state-entry edge.
- Acknowledge rules:
  - An ack that arrives before its request (e.g. stale hs_ack_s=1 in GO_HS entry cycle from a prior switch) is accepted only if both ack conditions hold. Both-high or both-low acks never complete a transition.
  - Acknowledge changes outside GO_* states are ignored.
- Simultaneous events:
  - err_clr and a new timeout in the same cycle: the set wins.
  - slow_req rising in the cycle HS is entered: HS lasts exactly 1 cycle, then GO_LS.
- Reset mid-switch: immediate return to LS with hsclk_sel=0. The clock switch is itself reset, so no handshake is needed.

Decomposition:
- Shared clock-control package: state encoding constants (LS=2'd0, GO_HS=2'd1, HS=2'd2, GO_LS=2'd3) and default LS_HOLD/TIMEOUT values, shared with the clock switch bench.
- One sub-module, `sync_ff` (parameter STAGES, RESET_VAL). It is instantiated twice, for hsclk_selected and lsclk_selected.

Test Plan:
1. Reset release with turbo_en=1, slow_req=0, acks idle (hs=0, ls=1):
   - hsclk_sel rises LS_HOLD+1 cycles after reset release.
   - Drive hs=1, ls=0 → hs_active=1 at SYNC_STAGES+1 cycles after the ack change.
2. In HS, pulse slow_req=1:
   - hsclk_sel=0 next cycle, busy=1.
   - Return acks to ls=1, hs=0 → busy=0 after SYNC_STAGES+1 cycles.
   - hsclk_sel stays 0 until slow_req=0 and 8 further cycles elapse.
3. In GO_HS, hold acks at hs=0, ls=1 for 255 cycles:
   - timeout_err=1, hsclk_sel=0 (GO_LS), then LS.
   - err_clr pulse → timeout_err=0.
4. slow_req=1 during GO_HS, acks arrive:
   - state passes HS for exactly 1 cycle (hs_active pulse of width 1), then GO_LS.
   - hsclk_sel is never re-asserted before ls ack completes.
5. Glitch ack: in GO_LS drive both acks=1 for 10 cycles → no LS entry, busy stays 1. Then hs=0 → LS.
6. Assert rst_b low mid-GO_HS → all outputs 0 immediately, no clock edge needed. After release, holdoff counts the full LS_HOLD=8 again.

Source files
------------

// File: rtl/clksel_pkg.sv
// Clock-control shared definitions: FSM state encoding, default timing values, ack decode.
package clksel_pkg;

    typedef enum logic [1:0] {
        ST_LS    = 2'd0,
        ST_GO_HS = 2'd1,
        ST_HS    = 2'd2,
        ST_GO_LS = 2'd3
    } clk_state_e;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned LS_HOLD_DEFAULT     = 8;
    localparam int unsigned TIMEOUT_DEFAULT     = 255;
    localparam int unsigned CNT_W_DEFAULT       = 8;

    // A switch is acknowledged only when exactly the wanted side reports selected.
    function automatic logic ack_is(input logic want_hs, input logic hs_ack, input logic ls_ack);
        return (hs_ack == want_hs) && (ls_ack == !want_hs);
    endfunction

endpackage

// File: rtl/clksel_ctrl_sync_ff.sv
// Multi-flop synchroniser for a single acknowledge bit, with a selectable reset value.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/clksel_ctrl.sv
// Requester side of the CPU fast/slow clock-switch handshake.
module clksel_ctrl
    import clksel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int unsigned LS_HOLD     = LS_HOLD_DEFAULT,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic hsclk_in,
    input  logic rst_b,
    input  logic turbo_en,
    input  logic slow_req,
    input  logic hsclk_selected,
    input  logic lsclk_selected,
    input  logic err_clr,
    output logic hsclk_sel,
    output logic hs_active,
    output logic busy,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(LS_HOLD);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TMO_EXT = (CNT_W+1)'(TIMEOUT);

    clk_state_e       r_state;
    clk_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_holdoff;
    logic [CNT_W-1:0] w_holdoff_nxt;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] w_tcnt_nxt;
    logic [CNT_W:0]   w_tcnt_inc;
    logic             w_tmo_hit;
    logic             w_err_set;
    logic             w_hs_ack_s;
    logic             w_ls_ack_s;
    logic             r_hsclk_sel;
    logic             r_hs_active;
    logic             r_busy;
    logic             r_timeout_err;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_hs_sync (
        .i_clk   (hsclk_in),
        .i_rst_b (rst_b),
        .i_d     (hsclk_selected),
        .o_q     (w_hs_ack_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ls_sync (
        .i_clk   (hsclk_in),
        .i_rst_b (rst_b),
        .i_d     (lsclk_selected),
        .o_q     (w_ls_ack_s)
    );

    assign w_tcnt_inc = {1'b0, r_tcnt} + (CNT_W+1)'(1);
    assign w_tmo_hit  = (w_tcnt_inc == TMO_EXT);

    // Next-state, counter and timeout-set decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_holdoff_nxt = r_holdoff;
        w_tcnt_nxt    = '0;
        w_err_set     = 1'b0;

        case (r_state)
            ST_LS: begin
                if (slow_req || !turbo_en) begin
                    w_holdoff_nxt = HOLD_LD;
                end else if (r_holdoff == '0) begin
                    w_state_nxt = ST_GO_HS;
                end else begin
                    w_holdoff_nxt = r_holdoff - CNT_W'(1);
                end
            end
            ST_GO_HS: begin
                if (ack_is(1'b1, w_hs_ack_s, w_ls_ack_s)) begin
                    w_state_nxt = ST_HS;
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_GO_LS;
                end
            end
            ST_HS: begin
                if (slow_req || !turbo_en) begin
                    w_state_nxt = ST_GO_LS;
                end
            end
            ST_GO_LS: begin
                // LS is the only safe place to fall back to, so a timeout here just flags and keeps waiting.
                if (ack_is(1'b0, w_hs_ack_s, w_ls_ack_s)) begin
                    w_state_nxt = ST_LS;
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LS;
            end
        endcase

        // Holdoff sits loaded outside LS so LS is always entered with a full hold.
        if (r_state != ST_LS) begin
            w_holdoff_nxt = HOLD_LD;
        end

        if ((w_state_nxt == r_state) && ((r_state == ST_GO_HS) || (r_state == ST_GO_LS))) begin
            w_tcnt_nxt = (r_tcnt == TMO_MAX) ? TMO_MAX : CNT_W'(w_tcnt_inc);
        end
    end

    // State and counter registers.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= ST_LS;
            r_holdoff <= HOLD_LD;
            r_tcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_holdoff <= w_holdoff_nxt;
            r_tcnt    <= w_tcnt_nxt;
        end
    end

    // Outputs registered from the next state so they move on the state-entry edge.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_hsclk_sel   <= 1'b0;
            r_hs_active   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_hsclk_sel <= (w_state_nxt == ST_GO_HS) || (w_state_nxt == ST_HS);
            r_hs_active <= (w_state_nxt == ST_HS);
            r_busy      <= (w_state_nxt == ST_GO_HS) || (w_state_nxt == ST_GO_LS);
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign hsclk_sel   = r_hsclk_sel;
    assign hs_active   = r_hs_active;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Bench for clksel_ctrl: directed handshake scenarios plus randomized traffic against a reference model.
module tb_clksel_ctrl;

    localparam int SYNC = 2;
    localparam int HOLD = 8;
    localparam int TMO  = 255;

    localparam int M_SLOW    = 0;
    localparam int M_TO_FAST = 1;
    localparam int M_FAST    = 2;
    localparam int M_TO_SLOW = 3;

    logic hsclk_in;
    logic rst_b;
    logic turbo_en;
    logic slow_req;
    logic hsclk_selected;
    logic lsclk_selected;
    logic err_clr;
    logic hsclk_sel;
    logic hs_active;
    logic busy;
    logic timeout_err;

    int n_run;
    int n_fail;

    // Reference model: mode, quiet-cycle run length, cycles spent waiting, sticky error, ack delay lines.
    int m_mode;
    int m_quiet;
    int m_wait;
    bit m_err;
    bit m_hs_q[$];
    bit m_ls_q[$];

    clksel_ctrl dut (
        .hsclk_in       (hsclk_in),
        .rst_b          (rst_b),
        .turbo_en       (turbo_en),
        .slow_req       (slow_req),
        .hsclk_selected (hsclk_selected),
        .lsclk_selected (lsclk_selected),
        .err_clr        (err_clr),
        .hsclk_sel      (hsclk_sel),
        .hs_active      (hs_active),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial begin
        hsclk_in = 1'b0;
        forever #5 hsclk_in = ~hsclk_in;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic model_reset();
        m_mode  = M_SLOW;
        m_quiet = 0;
        m_wait  = 0;
        m_err   = 1'b0;
        m_hs_q  = {};
        m_ls_q  = {};
        for (int i = 0; i < SYNC; i++) begin
            m_hs_q.push_back(1'b0);
            m_ls_q.push_back(1'b1);
        end
    endtask

    task automatic model_step();
        bit hs_s;
        bit ls_s;
        bit set_err;
        int nm;
        hs_s    = m_hs_q[0];
        ls_s    = m_ls_q[0];
        nm      = m_mode;
        set_err = 1'b0;
        case (m_mode)
            M_SLOW: begin
                if (turbo_en && !slow_req) begin
                    if (m_quiet >= HOLD) nm = M_TO_FAST;
                    else m_quiet++;
                end else begin
                    m_quiet = 0;
                end
            end
            M_TO_FAST: begin
                if (hs_s && !ls_s) nm = M_FAST;
                else if (m_wait + 1 >= TMO) begin
                    set_err = 1'b1;
                    nm = M_TO_SLOW;
                end
            end
            M_FAST: begin
                if (slow_req || !turbo_en) nm = M_TO_SLOW;
            end
            default: begin
                if (ls_s && !hs_s) nm = M_SLOW;
                else if (m_wait + 1 == TMO) set_err = 1'b1;
            end
        endcase
        if (nm != m_mode) begin
            m_wait  = 0;
            m_quiet = 0;
        end else begin
            m_wait++;
        end
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        void'(m_hs_q.pop_front());
        void'(m_ls_q.pop_front());
        m_hs_q.push_back(hsclk_selected);
        m_ls_q.push_back(lsclk_selected);
        m_mode = nm;
    endtask

    function automatic logic [3:0] model_outs();
        return {(m_mode == M_TO_FAST) || (m_mode == M_FAST),
                (m_mode == M_FAST),
                (m_mode == M_TO_FAST) || (m_mode == M_TO_SLOW),
                m_err};
    endfunction

    // One clock: model follows the edge, then return on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge hsclk_in);
        if (!rst_b) model_reset();
        else model_step();
        @(negedge hsclk_in);
    endtask

    function automatic logic get_out(input int which);
        case (which)
            0:       return hsclk_sel;
            1:       return hs_active;
            default: return busy;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int limit, output int n);
        n = 0;
        while ((get_out(which) !== val) && (n < limit)) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        turbo_en = 1'b1;
        slow_req = 1'b0;
        hsclk_selected = 1'b0;
        lsclk_selected = 1'b1;
        err_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        n_run++;
        if ({hsclk_sel, hs_active, busy, timeout_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b, want 0000", {hsclk_sel, hs_active, busy, timeout_err});
        end
    endtask

    task automatic test_fast_entry();
        int n;
        rst_b = 1'b1;
        wait_sig(0, 1'b1, 50, n);
        n_run++;
        if (n !== HOLD + 1) begin
            n_fail++;
            $display("FAIL fast_entry_hold: got %0d cycles, want %0d", n, HOLD + 1);
        end
        n_run++;
        if ({hs_active, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL fast_entry_busy: got %b, want 01", {hs_active, busy});
        end
        hsclk_selected = 1'b1;
        lsclk_selected = 1'b0;
        wait_sig(1, 1'b1, 20, n);
        n_run++;
        if (n !== SYNC + 1) begin
            n_fail++;
            $display("FAIL fast_entry_ack: got %0d cycles, want %0d", n, SYNC + 1);
        end
        n_run++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL fast_entry_settled: got %b, want 10", {hsclk_sel, busy});
        end
    endtask

    task automatic test_slow_exit();
        int n;
        repeat (2) tick();
        slow_req = 1'b1;
        tick();
        n_run++;
        if ({hsclk_sel, hs_active, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL slow_exit_req: got %b, want 001", {hsclk_sel, hs_active, busy});
        end
        hsclk_selected = 1'b0;
        lsclk_selected = 1'b1;
        wait_sig(2, 1'b0, 20, n);
        n_run++;
        if (n !== SYNC + 1) begin
            n_fail++;
            $display("FAIL slow_exit_ack: got %0d cycles, want %0d", n, SYNC + 1);
        end
        repeat (5) tick();
        n_run++;
        if (hsclk_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_exit_hold: got %b, want 0", hsclk_sel);
        end
        slow_req = 1'b0;
        wait_sig(0, 1'b1, 50, n);
        n_run++;
        if (n !== HOLD + 1) begin
            n_fail++;
            $display("FAIL slow_exit_rearm: got %0d cycles, want %0d", n, HOLD + 1);
        end
    endtask

    task automatic test_timeout();
        int n;
        wait_sig(0, 1'b0, 400, n);
        n_run++;
        if (n !== TMO) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d cycles, want %0d", n, TMO);
        end
        n_run++;
        if ({timeout_err, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_flag: got %b, want 11", {timeout_err, busy});
        end
        tick();
        n_run++;
        if ({hsclk_sel, busy, timeout_err} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_to_ls: got %b, want 001", {hsclk_sel, busy, timeout_err});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_run++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clr: got %b, want 0", timeout_err);
        end
    endtask

    task automatic test_slow_during_go_hs();
        int n;
        int pulses;
        int rerise;
        logic prev;
        wait_sig(0, 1'b1, 50, n);
        slow_req = 1'b1;
        hsclk_selected = 1'b1;
        lsclk_selected = 1'b0;
        pulses = 0;
        rerise = 0;
        prev = hsclk_sel;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (hs_active === 1'b1) pulses++;
            if (hsclk_sel === 1'b1 && prev === 1'b0) rerise++;
            prev = hsclk_sel;
        end
        n_run++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL hs_pulse_width: got %0d cycles, want 1", pulses);
        end
        n_run++;
        if (rerise !== 0) begin
            n_fail++;
            $display("FAIL hs_no_reassert: got %0d rises, want 0", rerise);
        end
        n_run++;
        if ({hsclk_sel, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL hs_pulse_go_ls: got %b, want 01", {hsclk_sel, busy});
        end
    endtask

    task automatic test_glitch_ack();
        int n;
        int bad;
        lsclk_selected = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (busy !== 1'b1 || hsclk_sel !== 1'b0) bad++;
        end
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL glitch_hold: got %0d bad cycles, want 0", bad);
        end
        hsclk_selected = 1'b0;
        wait_sig(2, 1'b0, 20, n);
        n_run++;
        if (n !== SYNC + 1) begin
            n_fail++;
            $display("FAIL glitch_release: got %0d cycles, want %0d", n, SYNC + 1);
        end
        slow_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        wait_sig(0, 1'b1, 50, n);
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got busy %b, want 1", busy);
        end
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        n_run++;
        if ({hsclk_sel, hs_active, busy, timeout_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b, want 0000", {hsclk_sel, hs_active, busy, timeout_err});
        end
        tick();
        tick();
        rst_b = 1'b1;
        wait_sig(0, 1'b1, 50, n);
        n_run++;
        if (n !== HOLD + 1) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %0d cycles, want %0d", n, HOLD + 1);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp;
        logic [3:0] act;
        logic want;
        bit stall;
        stall = 1'b0;
        rst_b = 1'b0;
        hsclk_selected = 1'b0;
        lsclk_selected = 1'b1;
        model_reset();
        tick();
        rst_b = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            exp = model_outs();
            act = {hsclk_sel, hs_active, busy, timeout_err};
            n_run++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b, want %b (sel,active,busy,err)", cyc, act, exp);
            end
            if ($urandom_range(0, 59) == 0) turbo_en = ~turbo_en;
            if ($urandom_range(0, 15) == 0) slow_req = ~slow_req;
            err_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) stall = ~stall;
            want = hsclk_sel;
            if (!stall && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0 && hsclk_selected != want) hsclk_selected = want;
                else if (lsclk_selected != !want) lsclk_selected = !want;
                else if (hsclk_selected != want) hsclk_selected = want;
            end
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 1) == 0) hsclk_selected = ~hsclk_selected;
                else lsclk_selected = ~lsclk_selected;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst_b = 1'b0;
                model_reset();
                tick();
                rst_b = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_fast_entry();
        test_slow_exit();
        test_timeout();
        test_slow_during_go_hs();
        test_glitch_ack();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
